// File: rtl/memory_writeback_stage_pkg.sv
// Shared constants and types for the MEM/WB boundary of the 16-bit CPU.
// Select encoding: WBS_MEM picks load data, WBS_ALU picks the ALU result.
package wb_pkg;
    localparam int DATA_W = 16;

    typedef logic [DATA_W-1:0] data_t;

    localparam logic WBS_MEM = 1'b0;
    localparam logic WBS_ALU = 1'b1;
endpackage

// File: rtl/memory_writeback_stage_if.sv
// MEM -> WB boundary signals.
// master is the MEM-side producer and WB-side consumer; slave is the pipeline register.
interface memory_writeback_stage_if
    import wb_pkg::*;
#(
    parameter int DATA_W = wb_pkg::DATA_W
) ();
    logic              en;
    logic              flush;
    logic              wbs_in;
    logic [DATA_W-1:0] memData_in;
    logic [DATA_W-1:0] calcData_in;
    logic              ni_in;

    logic              wbs_out;
    logic [DATA_W-1:0] memData_out;
    logic [DATA_W-1:0] calcData_out;
    logic              ni_out;
    logic [DATA_W-1:0] wb_data;

    modport master (
        output en, flush, wbs_in, memData_in, calcData_in, ni_in,
        input  wbs_out, memData_out, calcData_out, ni_out, wb_data
    );

    modport slave (
        input  en, flush, wbs_in, memData_in, calcData_in, ni_in,
        output wbs_out, memData_out, calcData_out, ni_out, wb_data
    );
endinterface

// File: rtl/memory_writeback_stage_mux2.sv
// Parameterised 2:1 mux: select=0 passes data0, select=1 passes data1.
module wb_mux2
    import wb_pkg::*;
#(
    parameter int W = wb_pkg::DATA_W
) (
    input  logic [W-1:0] data0,
    input  logic [W-1:0] data1,
    input  logic         select,
    output logic [W-1:0] out
);
    assign out = (select == WBS_ALU) ? data1 : data0;
endmodule

// File: rtl/memory_writeback_stage.sv
// MEM/WB pipeline register with stall and flush, plus the final writeback-value mux.
// wb_data is built only from registered values so it never glitches on MEM inputs.
module memory_writeback_stage
    import wb_pkg::*;
#(
    parameter int DATA_W = wb_pkg::DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    memory_writeback_stage_if.slave  bus
);
    logic              wbs_reg;
    logic [DATA_W-1:0] mem_data_reg;
    logic [DATA_W-1:0] calc_data_reg;
    logic              ni_reg;
    logic [DATA_W-1:0] wb_data_mux;

    // Flush clears exactly like reset so a bubble carries no writeback.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            wbs_reg       <= WBS_MEM;
            mem_data_reg  <= '0;
            calc_data_reg <= '0;
            ni_reg        <= 1'b0;
        end else if (bus.en) begin
            wbs_reg       <= bus.wbs_in;
            mem_data_reg  <= bus.memData_in;
            calc_data_reg <= bus.calcData_in;
            ni_reg        <= bus.ni_in;
        end
    end

    wb_mux2 #(.W(DATA_W)) u_wb_mux (
        .data0  (mem_data_reg),
        .data1  (calc_data_reg),
        .select (wbs_reg),
        .out    (wb_data_mux)
    );

    assign bus.wbs_out      = wbs_reg;
    assign bus.memData_out  = mem_data_reg;
    assign bus.calcData_out = calc_data_reg;
    assign bus.ni_out       = ni_reg;
    assign bus.wb_data      = wb_data_mux;
endmodule

// File: tb/tb_memory_writeback_stage.sv
// Scoreboard bench for memory_writeback_stage: the stimulus side predicts each edge's
// outputs into a queue, and a monitor checks them just after the edge and mid-cycle.
module tb_memory_writeback_stage;
    import wb_pkg::*;

    typedef struct packed {
        logic  wbs;
        data_t mem;
        data_t calc;
        logic  ni;
        data_t wbd;
    } exp_t;

    logic clk;
    logic rst;

    memory_writeback_stage_if #(.DATA_W(DATA_W)) bus ();

    memory_writeback_stage #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    exp_t  exp_q[$];
    exp_t  model_state;
    int    n_checks = 0;
    int    n_pass   = 0;
    int    step_no  = 0;

    // Reference: a pipeline register holds the last accepted transaction, zero after rst/flush.
    task automatic step(input logic r, input logic fl, input logic e, input logic w,
                        input data_t m, input data_t c, input logic n);
        exp_t nxt;
        @(negedge clk);
        rst             = r;
        bus.flush       = fl;
        bus.en          = e;
        bus.wbs_in      = w;
        bus.memData_in  = m;
        bus.calcData_in = c;
        bus.ni_in       = n;
        nxt = model_state;
        if (r || fl) begin
            nxt = '0;
        end else if (e) begin
            nxt.wbs  = w;
            nxt.mem  = m;
            nxt.calc = c;
            nxt.ni   = n;
        end
        nxt.wbd = (nxt.wbs == WBS_ALU) ? nxt.calc : nxt.mem;
        model_state = nxt;
        exp_q.push_back(nxt);
    endtask

    task automatic compare(input string tag, input int idx, input exp_t e);
        exp_t got;
        got.wbs  = bus.wbs_out;
        got.mem  = bus.memData_out;
        got.calc = bus.calcData_out;
        got.ni   = bus.ni_out;
        got.wbd  = bus.wb_data;
        n_checks++;
        if (got === e) begin
            n_pass++;
        end else begin
            $display("FAIL %s edge %0d: got wbs=%b mem=%h calc=%h ni=%b wb_data=%h, want wbs=%b mem=%h calc=%h ni=%b wb_data=%h",
                     tag, idx, got.wbs, got.mem, got.calc, got.ni, got.wbd,
                     e.wbs, e.mem, e.calc, e.ni, e.wbd);
        end
    endtask

    // Monitor: check right after each edge, then again after inputs have changed mid-cycle.
    initial begin
        exp_t cur;
        int   idx;
        idx = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                idx++;
                compare("post_edge", idx, cur);
                $display("edge %0d: wbs=%b mem=%h calc=%h ni=%b wb_data=%h",
                         idx, bus.wbs_out, bus.memData_out, bus.calcData_out,
                         bus.ni_out, bus.wb_data);
                #14;
                compare("mid_cycle", idx, cur);
            end
        end
    end

    initial begin
        int wait_cycles;
        model_state     = '0;
        rst             = 1'b1;
        bus.flush       = 1'b0;
        bus.en          = 1'b1;
        bus.wbs_in      = 1'b1;
        bus.memData_in  = 16'h1234;
        bus.calcData_in = 16'h4321;
        bus.ni_in       = 1'b1;

        // 1: reset with arbitrary inputs
        step(1'b1, 1'b0, 1'b1, 1'b1, 16'hBEEF, 16'hCAFE, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0F0F, 16'hF0F0, 1'b1);
        // 2..4: captures with each select value
        step(1'b0, 1'b0, 1'b1, WBS_ALU, 16'h00FF, 16'hFF00, 1'b1);
        step(1'b0, 1'b0, 1'b1, WBS_MEM, 16'h5555, 16'hAAAA, 1'b0);
        step(1'b0, 1'b0, 1'b1, WBS_ALU, 16'hAAAA, 16'h5555, 1'b1);
        // 5: stall for three edges while inputs churn
        step(1'b0, 1'b0, 1'b0, WBS_MEM, 16'h1111, 16'h2222, 1'b0);
        step(1'b0, 1'b0, 1'b0, WBS_ALU, 16'h3333, 16'h4444, 1'b0);
        step(1'b0, 1'b0, 1'b0, WBS_MEM, 16'hFFFF, 16'h0001, 1'b0);
        // 6: flush beats en, then reset beats en
        step(1'b0, 1'b1, 1'b1, WBS_ALU, 16'h9999, 16'h7777, 1'b1);
        step(1'b0, 1'b0, 1'b1, WBS_ALU, 16'h8001, 16'h7FFE, 1'b1);
        step(1'b1, 1'b0, 1'b1, WBS_ALU, 16'h6666, 16'h8888, 1'b1);
        // first edge after reset captures normally
        step(1'b0, 1'b0, 1'b1, WBS_MEM, 16'hFFFF, 16'h0000, 1'b0);

        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(15) == 0), ($urandom_range(7) == 0), ($urandom_range(3) != 0),
                 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
        end

        wait_cycles = 0;
        while (exp_q.size() != 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        @(posedge clk);
        #16;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
